// File: rtl/image_blitter_pkg.sv
// Shared types and constants for the image blitter: FSM encoding, default
// colour depth, screen geometry and the ROM address-width helper.
package image_blitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

  localparam int COLOUR_W_DEF = 12;
  localparam int SCR_W_DEF    = 160;
  localparam int SCR_H_DEF    = 120;
  localparam int COORD_W      = 8;

  // A single-pixel image still needs a one-bit address port.
  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/image_blitter_delay_line.sv
// ROM_LAT-stage pipeline carrying {valid, x, y, clip} alongside the ROM read;
// the last stage merges in the ROM-dependent key test and pixel colour.
module blit_delay_line
  import image_blitter_pkg::*;
#(
  parameter int STAGES   = 1,
  parameter int COLOUR_W = COLOUR_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                src_vld,
  input  logic [COORD_W-1:0]  src_x,
  input  logic [COORD_W-1:0]  src_y,
  input  logic                src_clip,
  input  logic                last_kill,
  input  logic [COLOUR_W-1:0] last_colour,
  output logic                plot,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour
);

  logic               vld_t;
  logic               clip_t;
  logic [COORD_W-1:0] x_t;
  logic [COORD_W-1:0] y_t;

  if (STAGES == 1) begin : g_direct
    assign vld_t  = src_vld;
    assign clip_t = src_clip;
    assign x_t    = src_x;
    assign y_t    = src_y;
  end else begin : g_chain
    logic [STAGES-2:0]              vld_p;
    logic [STAGES-2:0]              clip_p;
    logic [STAGES-2:0][COORD_W-1:0] x_p;
    logic [STAGES-2:0][COORD_W-1:0] y_p;

    // Stages 0..STAGES-2: plain delay while the ROM read is in flight
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_p  <= '0;
        clip_p <= '0;
        x_p    <= '0;
        y_p    <= '0;
      end else begin
        vld_p[0]  <= src_vld;
        clip_p[0] <= src_clip;
        x_p[0]    <= src_x;
        y_p[0]    <= src_y;
        for (int i = 1; i < STAGES - 1; i++) begin
          vld_p[i]  <= vld_p[i-1];
          clip_p[i] <= clip_p[i-1];
          x_p[i]    <= x_p[i-1];
          y_p[i]    <= y_p[i-1];
        end
      end
    end

    assign vld_t  = vld_p[STAGES-2];
    assign clip_t = clip_p[STAGES-2];
    assign x_t    = x_p[STAGES-2];
    assign y_t    = y_p[STAGES-2];
  end

  // Final stage: ROM data is valid now, so the key test lands in the same edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= vld_t & ~clip_t & ~last_kill;
      if (vld_t) begin
        x      <= x_t;
        y      <= y_t;
        colour <= last_colour;
      end
    end
  end

endmodule

// File: rtl/image_blitter.sv
// Image blitter: scans an IMG_W x IMG_H image out of ROM (or a solid fill),
// offsets it to (org_x, org_y), clips to the screen and drives VGA plot strobes.
module image_blitter
  import image_blitter_pkg::*;
#(
  parameter int  IMG_W    = 160,
  parameter int  IMG_H    = 120,
  parameter int  SCR_W    = SCR_W_DEF,
  parameter int  SCR_H    = SCR_H_DEF,
  parameter int  COLOUR_W = COLOUR_W_DEF,
  parameter int  ROM_LAT  = 1,
  localparam int ADDR_W   = addr_width(IMG_W * IMG_H)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [7:0]          org_x,
  input  logic [7:0]          org_y,
  input  logic                key_en,
  input  logic [COLOUR_W-1:0] key_colour,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [7:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  blit_state_t         state;
  blit_state_t         next_state;
  logic [8:0]          col;
  logic [8:0]          row;
  logic [1:0]          drain_cnt;
  logic                last_addr;

  logic                mode_l;
  logic                key_en_l;
  logic [7:0]          org_x_l;
  logic [7:0]          org_y_l;
  logic [COLOUR_W-1:0] key_l;
  logic [COLOUR_W-1:0] fill_l;

  logic                scan_vld;
  logic [8:0]          x9;
  logic [8:0]          y9;
  logic                clip;
  logic                kill;
  logic [COLOUR_W-1:0] pix_colour;

  assign last_addr = (col == 9'(IMG_W - 1)) && (row == 9'(IMG_H - 1));

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = ST_SCAN;
      ST_SCAN:  if (last_addr) next_state = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'(ROM_LAT - 1)) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // busy/done are registered from next_state so they line up with the state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ST_SCAN) || (next_state == ST_DRAIN);
      done  <= (next_state == ST_DONE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      rom_addr  <= '0;
      drain_cnt <= '0;
      mode_l    <= 1'b0;
      key_en_l  <= 1'b0;
      org_x_l   <= '0;
      org_y_l   <= '0;
      key_l     <= '0;
      fill_l    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          drain_cnt <= '0;
          if (start) begin
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            mode_l   <= mode;
            key_en_l <= key_en;
            org_x_l  <= org_x;
            org_y_l  <= org_y;
            key_l    <= key_colour;
            fill_l   <= fill_colour;
          end
        end
        ST_SCAN: begin
          drain_cnt <= '0;
          if (!last_addr) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            if (col == 9'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 9'd1;
            end else begin
              col <= col + 9'd1;
            end
          end
        end
        ST_DRAIN: drain_cnt <= drain_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Sums kept at 9 bits so off-screen pixels clip instead of wrapping
  assign scan_vld   = (state == ST_SCAN);
  assign x9         = {1'b0, org_x_l} + col;
  assign y9         = {1'b0, org_y_l} + row;
  assign clip       = (x9 >= 9'(SCR_W)) || (y9 >= 9'(SCR_H));
  assign kill       = ~mode_l & key_en_l & (rom_q == key_l);
  assign pix_colour = mode_l ? fill_l : rom_q;

  blit_delay_line #(
    .STAGES   (ROM_LAT),
    .COLOUR_W (COLOUR_W)
  ) u_delay (
    .clock       (clock),
    .reset       (reset),
    .src_vld     (scan_vld),
    .src_x       (x9[7:0]),
    .src_y       (y9[7:0]),
    .src_clip    (clip),
    .last_kill   (kill),
    .last_colour (pix_colour),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour)
  );

endmodule

// File: tb/tb_image_blitter.sv
// Bench for image_blitter with a 4x3 image and a ROM whose word equals its address.
module tb_image_blitter;

  localparam int IMG_W    = 4;
  localparam int IMG_H    = 3;
  localparam int ROM_LAT  = 1;
  localparam int COLOUR_W = 12;
  localparam int ADDR_W   = 4;
  localparam int NPIX     = IMG_W * IMG_H;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                mode = 1'b0;
  logic [7:0]          org_x = '0;
  logic [7:0]          org_y = '0;
  logic                key_en = 1'b0;
  logic [COLOUR_W-1:0] key_colour = '0;
  logic [COLOUR_W-1:0] fill_colour = '0;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_q;
  logic [7:0]          x;
  logic [7:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  always #5 clock = ~clock;

  // ROM word = address, presented in time for capture on the next edge
  assign rom_q = COLOUR_W'(rom_addr);

  image_blitter #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .SCR_W    (160),
    .SCR_H    (120),
    .COLOUR_W (COLOUR_W),
    .ROM_LAT  (ROM_LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .org_x       (org_x),
    .org_y       (org_y),
    .key_en      (key_en),
    .key_colour  (key_colour),
    .fill_colour (fill_colour),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    logic        mode;
    logic [7:0]  ox;
    logic [7:0]  oy;
    logic        key_en;
    logic [11:0] key;
    logic [11:0] fill;
    int          exp_plots;
  } vec_t;

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tab[4];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   plots_seen = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc - start_cyc);
    end
  endtask

  // Scoreboard consumer: every plot must match the oldest expected pixel
  always @(negedge clock) begin
    if (plot) begin
      plots_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_plot", cyc - start_cyc, -1);
      end else begin
        mon_e = exp_q.pop_front();
        check("plot_cycle", cyc - start_cyc, mon_e.cyc);
        check("plot_x", int'(x), int'(mon_e.x));
        check("plot_y", int'(y), int'(mon_e.y));
        check("plot_colour", int'(colour), int'(mon_e.c));
      end
    end
  end

  // Reference model: expected pixels of a blit accepted at cycle s, up to cycle limit
  task automatic push_blit(input vec_t v, input int s, input int limit);
    int   a;
    int   px;
    int   py;
    int   t;
    exp_t e;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        a  = r * IMG_W + c;
        px = int'(v.ox) + c;
        py = int'(v.oy) + r;
        t  = s + 1 + a + ROM_LAT;
        if (t < limit && px < 160 && py < 120 &&
            !(v.mode == 1'b0 && v.key_en && a == int'(v.key))) begin
          e.x   = px[7:0];
          e.y   = py[7:0];
          e.c   = v.mode ? v.fill : 12'(a);
          e.cyc = t;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  function automatic int in_win(input int rel, input int s);
    return (s >= 0 && rel >= s + 1 && rel <= s + NPIX + ROM_LAT) ? 1 : 0;
  endfunction

  function automatic int exp_busy(input int rel, input int s0, input int s1, input int rst_at);
    if (rst_at >= 0 && rel >= rst_at) return 0;
    return (in_win(rel, s0) == 1 || in_win(rel, s1) == 1) ? 1 : 0;
  endfunction

  function automatic int exp_done(input int rel, input int s0, input int s1, input int rst_at);
    if (rst_at >= 0 && rel >= rst_at) return 0;
    return ((s0 >= 0 && rel == s0 + NPIX + ROM_LAT + 1) ||
            (s1 >= 0 && rel == s1 + NPIX + ROM_LAT + 1)) ? 1 : 0;
  endfunction

  // Drive one run: start pulses from mask, optional 2-cycle reset at rst_at
  task automatic run(input vec_t v, input logic [63:0] mask, input int s0, input int s1,
                     input int rst_at, input int ncyc, input int n_plots, input string tag);
    plots_seen  = 0;
    mode        = v.mode;
    org_x       = v.ox;
    org_y       = v.oy;
    key_en      = v.key_en;
    key_colour  = v.key;
    fill_colour = v.fill;
    @(posedge clock);
    #1;
    start_cyc = cyc;
    for (int rel = 0; rel < ncyc; rel++) begin
      if (rel > 0) begin
        @(posedge clock);
        #1;
      end
      start = mask[rel];
      reset = (rst_at >= 0 && rel >= rst_at && rel < rst_at + 2);
      #1;
      check({tag, "_busy"}, int'(busy), exp_busy(rel, s0, s1, rst_at));
      check({tag, "_done"}, int'(done), exp_done(rel, s0, s1, rst_at));
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    #1;
    check({tag, "_plot_count"}, plots_seen, n_plots);
    check({tag, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    tab[0] = '{1'b0, 8'd10,  8'd20,  1'b0, 12'h000, 12'h000, 12};
    tab[1] = '{1'b0, 8'd10,  8'd20,  1'b1, 12'h005, 12'h000, 11};
    tab[2] = '{1'b0, 8'd158, 8'd119, 1'b0, 12'h000, 12'h000, 2};
    tab[3] = '{1'b1, 8'd10,  8'd20,  1'b1, 12'h005, 12'hF00, 12};

    // Reset state, with start asserted alongside reset
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock);
    #1;
    check("rst_start_dropped", int'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      push_blit(tab[i], 0, 1000);
      run(tab[i], 64'h1, 0, -1, -1, 18, tab[i].exp_plots, $sformatf("vec%0d", i));
    end

    // Reset at cycle 6: only pixels before the reset survive, no done
    push_blit(tab[0], 0, 6);
    run(tab[0], 64'h1, 0, -1, 6, 14, 4, "midrst");
    push_blit(tab[0], 0, 1000);
    run(tab[0], 64'h1, 0, -1, -1, 18, 12, "after_rst");

    // Starts at 5 (scanning) and 14 (done cycle) ignored; 15 accepted
    push_blit(tab[0], 0, 1000);
    push_blit(tab[0], 15, 1000);
    run(tab[0], 64'h0000_0000_0000_C021, 0, 15, -1, 34, 24, "ignore");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
